// File: rtl/alu_md_pkg.sv
// Op-code definitions shared by the EX-stage ALU, the mult/div unit and the controller decoder.
package alu_md_defs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Codes 0..3 occupy the unit for several cycles; 4..7 never do.
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

  // Odd arithmetic codes (MULTU, DIVU) are the unsigned variants.
  function automatic logic md_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_md_md_unit.sv
// Multi-cycle multiply/divide unit: counter-timed ops over latched operands, HI/LO registers,
// and single-cycle MTHI/MTLO. HI/LO change only at completion or on a move.
module md_unit
  import alu_md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               neg_a, neg_b, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor, quo_u, rem_u, quo, rem;

  // Signed ops work on sign-extended or magnitude forms so one unsigned core serves both.
  always_comb begin
    sgn      = md_is_signed(op_q);
    ext_a    = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    ext_b    = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod     = ext_a * ext_b;

    neg_a    = sgn & a_q[WIDTH-1];
    neg_b    = sgn & b_q[WIDTH-1];
    mag_a    = neg_a ? -a_q : a_q;
    mag_b    = neg_b ? -b_q : b_q;
    div_zero = (b_q == '0);
    divisor  = div_zero ? WIDTH'(1) : mag_b;
    quo_u    = mag_a / divisor;
    rem_u    = mag_a % divisor;
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates back onto itself.
    quo      = (neg_a ^ neg_b) ? -quo_u : quo_u;
    rem      = neg_a ? -rem_u : rem_u;
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        if (!md_is_div(op_q)) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (!div_zero) begin
          hi_d = rem;
          lo_d = quo;
        end
      end
    end else if (start_i) begin
      case (op_i)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          a_d   = a_i;
          b_d   = b_i;
          op_d  = op_i;
          cnt_d = md_is_div(op_i) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
        MD_MTHI: hi_d = a_i;
        MD_MTLO: lo_d = a_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: zero-latency integer datapath plus the multi-cycle mult/div unit.
// stall holds back dependent instructions while the unit is, or is about to become, busy.
module alu_md
  import alu_md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       alu_ctrl,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = inA + inB;
      ALU_SUB:  result = inA - inB;
      ALU_OR:   result = inA | inB;
      ALU_AND:  result = inA & inB;
      ALU_XOR:  result = inA ^ inB;
      ALU_NOR:  result = ~(inA | inB);
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (inA < inB)};
      ALU_LUI:  result = inB << (WIDTH/2);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

  md_unit #(
    .WIDTH      (WIDTH),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .a_i    (inA),
    .b_i    (inB),
    .start_i(md_start),
    .op_i   (md_op),
    .hi_o   (hi),
    .lo_o   (lo),
    .busy_o (busy)
  );

  // A request arriving while busy is dropped, so the requester must be held off in the same cycle.
  assign stall = busy | (md_start & md_is_arith(md_op));

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: directed and random stimulus, expectations queued at issue, checked by a monitor.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inA, inB;
  logic [3:0]  alu_ctrl;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] result, hi, lo;
  logic        zero, busy, stall;

  alu_md dut (
    .clk(clk), .reset(reset), .inA(inA), .inB(inB), .alu_ctrl(alu_ctrl),
    .md_start(md_start), .md_op(md_op), .result(result), .zero(zero),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct { string nm; logic [31:0] hi; logic [31:0] lo; int cyc; } md_exp_t;
  typedef struct { logic [31:0] hi; logic [31:0] lo; logic busy; logic stall; } chk_exp_t;
  typedef struct { logic [31:0] res; logic z; } alu_exp_t;

  md_exp_t  md_q[$];
  chk_exp_t chk_q[$];
  alu_exp_t alu_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic alu_vld = 1'b0;
  logic chk_vld = 1'b0;
  logic [31:0] model_hi, model_lo;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the architectural meaning of each op, in 64-bit integer arithmetic.
  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a | b;
      4'd3: return a & b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  // Applies an accepted op to the HI/LO model; returns how many cycles the unit stays busy.
  function automatic int md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint q, r;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        model_hi = p[63:32]; model_lo = p[31:0];
        return 5;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        model_hi = p[63:32]; model_lo = p[31:0];
        return 5;
      end
      3'd2: begin
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          model_lo = q[31:0]; model_hi = r[31:0];
        end
        return 10;
      end
      3'd3: begin
        if (b != 0) begin
          model_lo = a / b; model_hi = a % b;
        end
        return 10;
      end
      3'd4: begin model_hi = a; return 0; end
      3'd5: begin model_lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  task automatic check_regs(input logic eb, input logic es);
    chk_exp_t e;
    e.hi = model_hi; e.lo = model_lo; e.busy = eb; e.stall = es;
    chk_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clk); #1;
    chk_vld = 1'b0;
  endtask

  task automatic alu_check(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_exp_t e;
    alu_ctrl = c; inA = a; inB = b;
    e.res = alu_ref(c, a, b);
    e.z   = (e.res == 32'd0);
    alu_q.push_back(e);
    alu_vld = 1'b1;
    @(negedge clk); #1;
    alu_vld = 1'b0;
  endtask

  // Issues one request from idle and waits until the unit is idle again.
  task automatic issue_md(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_exp_t e;
    int cyc;
    @(posedge clk); #1;
    inA = a; inB = b; md_op = op; md_start = 1'b1;
    check_regs(1'b0, (op < 3'd4));
    cyc = md_model(op, a, b);
    if (op < 3'd4) begin
      e.nm = nm; e.hi = model_hi; e.lo = model_lo; e.cyc = cyc;
      md_q.push_back(e);
    end
    @(posedge clk); #1;
    md_start = 1'b0; inA = $urandom; inB = $urandom;
    if (op < 3'd4) begin
      repeat (cyc) @(posedge clk);
      #1;
    end else begin
      check_regs(1'b0, 1'b0);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents something to check.
  initial begin
    logic busy_prev;
    int run;
    md_exp_t  me;
    chk_exp_t ce;
    alu_exp_t ae;
    busy_prev = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (alu_vld) begin
        if (alu_q.size() == 0) cmp("alu_queue_underflow", 1, 0);
        else begin
          ae = alu_q.pop_front();
          cmp("alu_result", result, ae.res);
          cmp("alu_zero", zero, ae.z);
        end
      end
      if (chk_vld) begin
        if (chk_q.size() == 0) cmp("chk_queue_underflow", 1, 0);
        else begin
          ce = chk_q.pop_front();
          cmp("regs_hi", hi, ce.hi);
          cmp("regs_lo", lo, ce.lo);
          cmp("regs_busy", busy, ce.busy);
          cmp("regs_stall", stall, ce.stall);
        end
      end
      if (busy === 1'b1) run++;
      if (busy_prev === 1'b1 && busy === 1'b0) begin
        if (md_q.size() == 0) cmp("md_unexpected_completion", 1, 0);
        else begin
          me = md_q.pop_front();
          cmp({me.nm, ".hi"}, hi, me.hi);
          cmp({me.nm, ".lo"}, lo, me.lo);
          cmp({me.nm, ".busy_cycles"}, run, me.cyc);
        end
        run = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    md_exp_t e;
    int cyc;
    reset = 1'b1; md_start = 1'b0; md_op = 3'd0; inA = 32'd0; inB = 32'd0; alu_ctrl = 4'd0;
    model_hi = 32'd0; model_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_regs(1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_regs(1'b0, 1'b0);

    alu_check(4'd0, 32'h7FFF_FFFF, 32'd1);
    alu_check(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    alu_check(4'd6, 32'hFFFF_FFFF, 32'd1);
    alu_check(4'd7, 32'hFFFF_FFFF, 32'd1);
    alu_check(4'd8, 32'd0, 32'h0000_1234);
    alu_check(4'd5, 32'hF0F0_0000, 32'h0000_0F0F);
    alu_check(4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
    alu_check(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Requests arriving while busy must be dropped.
    @(posedge clk); #1;
    inA = 32'd3; inB = 32'd4; md_op = 3'd0; md_start = 1'b1;
    check_regs(1'b0, 1'b1);
    cyc = md_model(3'd0, 32'd3, 32'd4);
    e.nm = "mult_3x4_ignored_reqs"; e.hi = model_hi; e.lo = model_lo; e.cyc = cyc;
    md_q.push_back(e);
    @(posedge clk); #1;
    model_hi = 32'd0; model_lo = 32'd0;
    md_op = 3'd4; inA = 32'h0000_AAAA; md_start = 1'b1;
    check_regs(1'b1, 1'b1);
    @(posedge clk); #1;
    md_op = 3'd0; inA = 32'd5; inB = 32'd5;
    check_regs(1'b1, 1'b1);
    @(posedge clk); #1;
    md_start = 1'b0;
    model_hi = 32'd0; model_lo = 32'd12;
    repeat (3) @(posedge clk);
    #1;

    issue_md("mtlo", 3'd5, 32'h55, 32'd0);
    issue_md("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3);
    issue_md("multu_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3);
    issue_md("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    issue_md("divu_7_0", 3'd3, 32'd7, 32'd0);
    issue_md("div_min_neg1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue_md("mthi", 3'd4, 32'hDEAD_BEEF, 32'd0);
    issue_md("ignored_op6", 3'd6, 32'h1111_1111, 32'd2);

    // Back-to-back with md_start held: second op must wait one idle cycle.
    @(posedge clk); #1;
    inA = 32'd6; inB = 32'd7; md_op = 3'd0; md_start = 1'b1;
    check_regs(1'b0, 1'b1);
    cyc = md_model(3'd0, 32'd6, 32'd7);
    e.nm = "b2b_first"; e.hi = model_hi; e.lo = model_lo; e.cyc = cyc;
    md_q.push_back(e);
    @(posedge clk); #1;
    inA = 32'hFFFF_FFF0; inB = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    check_regs(1'b0, 1'b1);
    cyc = md_model(3'd0, 32'hFFFF_FFF0, 32'd9);
    e.nm = "b2b_second"; e.hi = model_hi; e.lo = model_lo; e.cyc = cyc;
    md_q.push_back(e);
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Reset in the third busy cycle of a DIV aborts it and clears HI/LO.
    @(posedge clk); #1;
    inA = 32'd100; inB = 32'd7; md_op = 3'd2; md_start = 1'b1;
    e.nm = "div_reset_abort"; e.hi = 32'd0; e.lo = 32'd0; e.cyc = 3;
    md_q.push_back(e);
    @(posedge clk); #1;
    md_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    repeat (12) @(posedge clk);
    #1;
    check_regs(1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      alu_check(4'($urandom_range(0, 15)), $urandom, $urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      issue_md("rand_md", 3'($urandom_range(0, 7)), a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    cmp("md_queue_drained", md_q.size(), 0);
    cmp("chk_queue_drained", chk_q.size(), 0);
    cmp("alu_queue_drained", alu_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle ALU.
- Keeps a combinational integer datapath: add, sub, logic, compare and the lui-style shift-by-half-width.
- Adds a multi-cycle multiply/divide unit with HI/LO registers and a start/busy handshake.
- Sits in the EX stage; `stall` feeds the hazard unit so later HI/LO-dependent instructions wait.

Parameters:
- WIDTH, 32: datapath width in bits (even, ≥ 8).
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (≥ 1).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (≥ 1).
- CNT_W, 8: counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- inA  in  WIDTH  operand A.
- inB  in  WIDTH  operand B.
- alu_ctrl  in  4  ALU op: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 LUI; others → 0.
- md_start  in  1  request a multiply/divide/move this cycle.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; others ignored.
- result  out  WIDTH  combinational ALU result.
- zero  out  1  (result == 0).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  unit executing a mult/div.
- stall  out  1  busy | (md_start & md_op ∈ {0..3}).

Behaviour:
- **ALU path** (combinational, zero latency):
  - ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is signed and SLTU unsigned; both return 1 or 0 zero-extended.
  - LUI = inB << (WIDTH/2).
  - Undefined codes give 0.
- **Reset:** hi = 0, lo = 0, busy = 0, counter = 0, latched operands/op = 0. Reset mid-operation aborts the op; HI/LO still go to 0.
- **Idle:** counter == 0, busy = 0.
- **Mult/div start:** on an edge with busy = 0 and md_start = 1, md_op ∈ {0..3}:
  - inA, inB and md_op are latched.
  - counter is loaded with MULT_CYCLES (ops 0, 1) or DIV_CYCLES (ops 2, 3).
  - busy is high for exactly that many cycles after the start edge.
- **Completion:** on the edge where counter goes 1 → 0, HI/LO are written. New values are visible in the first cycle with busy = 0.
- **MULT/MULTU:** 2·WIDTH-bit product, signed or unsigned; HI = upper half, LO = lower half.
- **DIV/DIVU:**
  - LO = quotient, HI = remainder.
  - Signed: truncate toward zero; remainder takes the dividend's sign.
  - Signed most-negative / −1: LO = most-negative, HI = 0.
  - Divisor 0: busy runs the full DIV_CYCLES, HI/LO unchanged.
- **MTHI/MTLO:** with busy = 0 and md_start = 1, hi (or lo) ← inA at the edge. Single cycle; busy is not asserted.
- **Ignored requests:**
  - md_start while busy = 1 is ignored; the requester must hold it, with stall = 1 forcing that.
  - md_start with md_op 6/7 is ignored.
- **Back-to-back:** a new start is accepted on the same edge busy falls? No. It is accepted on the first edge where busy = 0 is sampled, i.e. one cycle after completion at the earliest.
- **hi/lo outputs** are registered and stable while busy. No bypass of in-flight results.

Decomposition:
- **Shared package** `alu_md_defs`:
  - ALU op codes (ALU_ADD…ALU_LUI, 4-bit).
  - MD op codes (MD_MULT…MD_MTLO, 3-bit).
  - Reused by the controller decoder.
- **Sub-module** `md_unit`:
  - Contains the counter, operand latches, HI/LO, and the mult/div arithmetic.
  - The ALU combinational path stays in the top module.

Test Plan:
- **ALU ops:** inA=0x7FFFFFFF, inB=1.
  - ADD → 0x80000000, zero = 0.
  - SUB with inB=0x7FFFFFFF → 0, zero = 1.
  - SLT with inA=0xFFFFFFFF, inB=1 → 1; SLTU → 0.
  - LUI with inB=0x1234 → 0x12340000.
- **MULT:** MULT inA=0xFFFFFFFE (−2), inB=3.
  - busy = 1 for exactly 5 cycles, stall = 1 in the start cycle.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- **DIV:** DIV inA=−7 (0xFFFFFFF9), inB=2.
  - After 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 → hi/lo keep their prior values, busy still 10 cycles.
- **Ignored while busy:** from hi=lo=0, start MULT 3×4.
  - During busy, pulse MTHI inA=0xAAAA, then a second MULT 5×5. Both are ignored.
  - Final hi=0, lo=12.
  - MTLO inA=0x55 when idle → lo=0x55 next cycle, busy stays 0.
- **Reset mid-op:** assert reset in the 3rd busy cycle of a DIV.
  - Next cycle: busy=0, hi=0, lo=0, and no later HI/LO update.
- **Boundaries:**
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Back-to-back MULT held asserted: second op starts the cycle after busy falls; results are sequential and correct.
